led_shift_out: RTL and testbench

- Downstream stage of the LED wave/PWM generator.
- Takes the 8-bit `led` vector and drives it off-board serially to a 74HC595-style shift/latch register: serial clock, serial data, latch strobe.
- Sends a new word only when the input differs from the last word sent.
- The input is captured atomically, so the external register never shows a half-shifted pattern.

---
 rtl/led_shift_out_pkg.sv | 22 ++
 rtl/led_shift_out_phase_timer.sv | 44 ++++
 rtl/led_shift_out.sv | 150 +++++++++++++++
 tb/tb_led_shift_out.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/led_shift_out_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : led_shift_out_pkg
//  Purpose : Definitions shared by the LED serial output stage: the default
//            LED vector width (the same one the wave generator uses) and the
//            transfer state encoding.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package led_shift_out_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle     = 2'd0;
    localparam state_t c_st_shift_lo = 2'd1;
    localparam state_t c_st_shift_hi = 2'd2;
    localparam state_t c_st_latch    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/led_shift_out_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module  : phase_timer
//  Purpose : Measures one phase of the serial transfer. A start pulse clears
//            the count. done is high during the CLK_DIV-th cycle after start,
//            and only during that cycle.
//  Ports   : clk   - system clock
//            rst   - synchronous active-high reset
//            start - restart the phase (the cycle after start is cycle 1)
//            done  - single-cycle pulse in the last cycle of the phase
//  Rev     : 1.0  initial release
// ============================================================================
module phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    // One extra count value so the counter can park past the terminal value
    // and done stays a pulse instead of a level.
    localparam int CNT_W = $clog2(CLK_DIV + 1);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_park = CNT_W'(CLK_DIV);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= '0;
        end else if (r_cnt != c_park) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign done = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/led_shift_out.sv
`default_nettype none
// ============================================================================
//  Module  : led_shift_out
//  Purpose : Serialises the LED vector to a 74HC595-style shift/latch chain,
//            MSB first. A word is sent only when led_in differs from the last
//            word sent. After reset, one transfer is always sent. led_in is
//            captured in a single cycle, so the external register never shows
//            a partially shifted pattern.
//  Ports   : clk    - system clock
//            rst    - synchronous active-high reset
//            led_in - LED vector, sampled only while idle
//            sclk   - serial shift clock
//            sdata  - serial data, stable through each sclk high phase
//            latch  - storage register strobe, active high
//            busy   - transfer in progress
//  Rev     : 1.0  initial release
// ============================================================================
module led_shift_out
    import led_shift_out_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] led_in,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             busy
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_shadow_next;
    logic             r_first;
    logic             w_first_next;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [BIT_W-1:0] w_bit_cnt_next;
    logic             w_phase_start;
    logic             w_phase_done;
    logic             w_sclk_next;
    logic             w_sdata_next;
    logic             w_latch_next;
    logic             w_busy_next;

    // Each state change starts a new phase. The timer tells the FSM when that
    // phase is over.
    assign w_phase_start = (w_state_next != r_state);

    phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .clk   (clk),
        .rst   (rst),
        .start (w_phase_start),
        .done  (w_phase_done)
    );

    // State register. The outputs are registered here with the state, so
    // every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_shift   <= '0;
            r_shadow  <= '0;
            r_first   <= 1'b1;
            r_bit_cnt <= '0;
            sclk      <= 1'b0;
            sdata     <= 1'b0;
            latch     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_shadow  <= w_shadow_next;
            r_first   <= w_first_next;
            r_bit_cnt <= w_bit_cnt_next;
            sclk      <= w_sclk_next;
            sdata     <= w_sdata_next;
            latch     <= w_latch_next;
            busy      <= w_busy_next;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_shadow_next  = r_shadow;
        w_first_next   = r_first;
        w_bit_cnt_next = r_bit_cnt;
        case (r_state)
            c_st_idle: begin
                if ((led_in != r_shadow) || r_first) begin
                    w_state_next   = c_st_shift_lo;
                    w_shift_next   = led_in;
                    w_shadow_next  = led_in;
                    w_first_next   = 1'b0;
                    w_bit_cnt_next = BIT_W'(WIDTH - 1);
                end
            end
            c_st_shift_lo: begin
                if (w_phase_done) begin
                    w_state_next = c_st_shift_hi;
                end
            end
            c_st_shift_hi: begin
                if (w_phase_done) begin
                    if (r_bit_cnt == '0) begin
                        w_state_next = c_st_latch;
                    end else begin
                        w_state_next   = c_st_shift_lo;
                        w_shift_next   = r_shift << 1;
                        w_bit_cnt_next = r_bit_cnt - BIT_W'(1);
                    end
                end
            end
            c_st_latch: begin
                if (w_phase_done) begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // Output decode. The next output values are computed from the next state
    // so the outputs change in the same cycle as the registered state.
    always_comb begin
        w_sclk_next  = (w_state_next == c_st_shift_hi);
        w_latch_next = (w_state_next == c_st_latch);
        w_busy_next  = (w_state_next != c_st_idle);
        w_sdata_next = 1'b0;
        case (w_state_next)
            c_st_shift_lo: w_sdata_next = w_shift_next[WIDTH-1];
            c_st_shift_hi: w_sdata_next = sdata;
            default:       w_sdata_next = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_led_shift_out.sv
`default_nettype none
// ============================================================================
//  Module  : tb_led_shift_out
//  Purpose : Self-checking bench for led_shift_out. It drives two instances
//            (CLK_DIV=4 and CLK_DIV=1) from the same stimulus and compares
//            them against a transfer-position reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_led_shift_out;

    localparam int W  = 8;
    localparam int D0 = 4;
    localparam int D1 = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] led_in;
    logic         a_sclk, a_sdata, a_latch, a_busy;
    logic         b_sclk, b_sdata, b_latch, b_busy;

    always #5 clk = ~clk;

    led_shift_out #(.WIDTH(W), .CLK_DIV(D0)) dut_a (
        .clk(clk), .rst(rst), .led_in(led_in),
        .sclk(a_sclk), .sdata(a_sdata), .latch(a_latch), .busy(a_busy)
    );

    led_shift_out #(.WIDTH(W), .CLK_DIV(D1)) dut_b (
        .clk(clk), .rst(rst), .led_in(led_in),
        .sclk(b_sclk), .sdata(b_sdata), .latch(b_latch), .busy(b_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model. A transfer is a position counter that runs from 0 to
    // (2W+1)*D-1. The outputs in each cycle follow from that position.
    int           pos   [2];
    int           div   [2];
    logic [W-1:0] word  [2];
    logic [W-1:0] last  [2];
    bit           first [2];

    // Observation counters for the directed segments
    int           cnt_busy  [2];
    int           cnt_rise  [2];
    int           cnt_latch [2];
    logic [W-1:0] shifted   [2];
    logic         prev_sclk [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] expect_out(int k);
        int d;
        int b;
        d = div[k];
        if (pos[k] < 0) return 4'b0000;
        if (pos[k] < 2 * W * d) begin
            b = pos[k] / (2 * d);
            return {1'b1, ((pos[k] % (2 * d)) >= d), word[k][W-1-b], 1'b0};
        end
        return 4'b1001;
    endfunction

    task automatic model_tick(int k);
        if (rst) begin
            pos[k]   = -1;
            last[k]  = '0;
            first[k] = 1'b1;
        end else if (pos[k] < 0) begin
            if ((led_in != last[k]) || first[k]) begin
                word[k]  = led_in;
                last[k]  = led_in;
                first[k] = 1'b0;
                pos[k]   = 0;
            end
        end else begin
            pos[k]++;
            if (pos[k] == (2 * W + 1) * div[k]) pos[k] = -1;
        end
    endtask

    task automatic observe(int k, logic bz, logic sc, logic sd, logic la);
        if (bz) cnt_busy[k]++;
        if (la) cnt_latch[k]++;
        if (sc && !prev_sclk[k]) begin
            cnt_rise[k]++;
            shifted[k] = {shifted[k][W-2:0], sd};
        end
        prev_sclk[k] = sc;
    endtask

    task automatic clear_obs();
        for (int k = 0; k < 2; k++) begin
            cnt_busy[k]  = 0;
            cnt_rise[k]  = 0;
            cnt_latch[k] = 0;
            shifted[k]   = '0;
        end
    endtask

    // One clock: update the model at the edge, sample the DUTs mid-cycle.
    task automatic step();
        @(posedge clk);
        model_tick(0);
        model_tick(1);
        @(negedge clk);
        check("out_div4", {28'd0, a_busy, a_sclk, a_sdata, a_latch}, {28'd0, expect_out(0)});
        check("out_div1", {28'd0, b_busy, b_sclk, b_sdata, b_latch}, {28'd0, expect_out(1)});
        observe(0, a_busy, a_sclk, a_sdata, a_latch);
        observe(1, b_busy, b_sclk, b_sdata, b_latch);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit reached;
        div[0] = D0;
        div[1] = D1;
        for (int k = 0; k < 2; k++) begin
            pos[k] = -1; last[k] = '0; first[k] = 1'b1; word[k] = '0; prev_sclk[k] = 1'b0;
        end
        clear_obs();
        rst    = 1'b1;
        led_in = '0;
        run(3);

        // Forced transfer of zero after reset
        rst = 1'b0;
        clear_obs();
        run(100);
        check("init_busy_a",  cnt_busy[0],  68);
        check("init_rise_a",  cnt_rise[0],  8);
        check("init_latch_a", cnt_latch[0], 4);
        check("init_word_a",  {24'd0, shifted[0]}, 32'h00);
        check("init_busy_b",  cnt_busy[1],  17);

        // Single word 8'hA5
        led_in = 8'hA5;
        clear_obs();
        run(100);
        check("a5_word_a", {24'd0, shifted[0]}, 32'hA5);
        check("a5_rise_a", cnt_rise[0], 8);
        check("a5_word_b", {24'd0, shifted[1]}, 32'hA5);

        // Unchanged input produces no activity
        clear_obs();
        run(500);
        check("hold_busy_a", cnt_busy[0], 0);
        check("hold_busy_b", cnt_busy[1], 0);
        check("hold_rise_a", cnt_rise[0], 0);

        // Input changes while a transfer is in progress: only the newest is sent
        led_in = 8'h0F;
        run(10);
        led_in = 8'h11;
        run(10);
        led_in = 8'h3C;
        clear_obs();
        run(200);
        check("newest_word_a", {24'd0, shifted[0]}, 32'h3C);

        // Reset pulse during the high phase of the fifth bit
        led_in  = ~last[0];
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            step();
            if (pos[0] == 4 * 2 * D0 + D0 + 1) reached = 1'b1;
        end
        check("rst_mid_reached", {31'd0, reached}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_outs", {28'd0, a_busy, a_sclk, a_sdata, a_latch}, 32'd0);
        clear_obs();
        run(100);
        check("rst_forced_word", {24'd0, shifted[0]}, {24'd0, led_in});

        // CLK_DIV=1 with all ones
        led_in = 8'h00;
        run(100);
        led_in = 8'hFF;
        clear_obs();
        run(100);
        check("ff_busy_b",  cnt_busy[1],  17);
        check("ff_rise_b",  cnt_rise[1],  8);
        check("ff_latch_b", cnt_latch[1], 1);
        check("ff_word_b",  {24'd0, shifted[1]}, 32'hFF);

        // Randomized stimulus
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0)
                led_in = ($urandom_range(0, 3) == 0) ? last[0] : W'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        run(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
